// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Sequential instruction fetch with a single outstanding memory
//            request, a DEPTH-entry {pc, inst} queue and redirect/flush support.
//            Optional macro FETCH_MISALIGN_CHECK_EN adds misaligned-redirect
//            fault reporting.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_fault
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [31:0]      c_nop     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_next;
    logic [31:0]      r_req_addr;
    logic [31:0]      r_q_pc   [DEPTH];
    logic [31:0]      r_q_inst [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [31:0]      w_target;
    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_room;
    logic             w_halt;

    assign w_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;
    logic w_fault_next;

    // A misaligned redirect latches the fault; only an aligned redirect clears it.
    assign w_fault_next = redirect ? (redirect_pc[1:0] != 2'b00) : r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fault <= 1'b0;
        else     r_fault <= w_fault_next;
    end

    assign misalign_fault = r_fault;
    assign w_halt         = w_fault_next;
`else
    logic w_unused_low_bits;
    assign w_unused_low_bits = ^redirect_pc[1:0];
    assign w_halt            = 1'b0;
`endif

    // The ack is meaningful only while a request is actually on the bus.
    assign w_ack  = imem_ack && (r_state != S_IDLE);
    assign w_push = (r_state == S_REQ) && w_ack && !redirect;
    assign w_pop  = (r_count != '0) && out_ready;

    always_comb begin
        w_count_next = r_count;
        if (redirect)
            w_count_next = '0;
        else if (w_push && !w_pop)
            w_count_next = r_count + c_cnt_one;
        else if (!w_push && w_pop)
            w_count_next = r_count - c_cnt_one;
    end

    assign w_room = (w_count_next < c_depth);

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (redirect)
            w_fetch_pc_next = w_target;
        else if (w_push)
            w_fetch_pc_next = r_fetch_pc + 32'd4;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; a redirect without ack leaves a stale request to drain.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_halt && w_room) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (w_ack)         w_state_next = (!w_halt && w_room) ? S_REQ : S_IDLE;
                else if (redirect) w_state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_ack)         w_state_next = (!w_halt && w_room) ? S_REQ : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = (r_state != S_IDLE);
        imem_addr = r_req_addr;
        out_valid = (r_count != '0);
        out_inst  = out_valid ? r_q_inst[r_head] : c_nop;
        out_pc    = out_valid ? r_q_pc[r_head]   : r_fetch_pc;
    end

    // req_addr may only move when no request is held on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            if ((r_state == S_IDLE) || w_ack)
                r_req_addr <= w_fetch_pc_next;
            if (redirect) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_pop)  r_head <= r_head + c_ptr_one;
                if (w_push) r_tail <= r_tail + c_ptr_one;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]   <= r_req_addr;
            r_q_inst[r_tail] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a configurable
//            latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 0;
    int wcnt;
    int ack_cnt;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory acks after mem_lat wait cycles of a held request.
    assign imem_ack   = imem_req && (wcnt == mem_lat);
    assign imem_rdata = inst_of(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= 0;
            ack_cnt <= 0;
        end else begin
            if (imem_req && !imem_ack) wcnt <= wcnt + 1;
            else                       wcnt <= 0;
            if (imem_req && imem_ack)  ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // Reset values and zero-wait streaming
        #1 rst = 1'b1;
        tick();
        check("rst_req",   32'(imem_req),  32'h0);
        check("rst_addr",  imem_addr,      32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_inst",  out_inst,       32'h0000_0013);
        check("rst_pc",    out_pc,         32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("first_req",  32'(imem_req), 32'h1);
        check("first_addr", imem_addr,      32'h0);
        tick();
        for (int k = 0; k < 6; k++) begin
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_pc",    out_pc,         32'(4 * k));
            check("stream_inst",  out_inst,       inst_of(32'(4 * k)));
            tick();
        end

        // Backpressure: queue fills after two acks, then fetch stops
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check("bp_req_off", 32'(imem_req), 32'h0);
        tick();
        tick();
        check("bp_req_off2", 32'(imem_req), 32'h0);
        check("bp_acks",     32'(ack_cnt),  32'd2);
        check("bp_head_pc",  out_pc,        32'h0);
        out_ready = 1'b1;
        tick();
        check("bp_pop2_pc",  out_pc,        32'h4);
        check("bp_resume",   32'(imem_req), 32'h1);
        check("bp_res_addr", imem_addr,     32'h8);
        tick();
        check("bp_pop3_pc",  out_pc,        32'h8);

        // Redirect during a 3-cycle-latency request
        mem_lat = 3;
        do_reset();
        tick();
        check("lat_addr0", imem_addr, 32'h0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("fl_req_held",  32'(imem_req),  32'h1);
        check("fl_addr_held", imem_addr,      32'h0);
        check("fl_valid",     32'(out_valid), 32'h0);
        check("fl_out_pc",    out_pc,         32'h100);
        tick();
        check("fl_stale_ack", 32'(imem_ack),  32'h1);
        check("fl_valid2",    32'(out_valid), 32'h0);
        tick();
        check("fl_new_addr",  imem_addr,      32'h100);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("fl_seen",  32'(seen), 32'h1);
        check("fl_pc",    out_pc,    32'h100);
        check("fl_inst",  out_inst,  inst_of(32'h100));

        // Redirect coinciding with an ack and a pop
        mem_lat = 0;
        do_reset();
        tick();
        tick();
        check("rp_pop_valid", 32'(out_valid), 32'h1);
        check("rp_pop_pc",    out_pc,         32'h0);
        check("rp_ack",       32'(imem_ack),  32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("rp_empty",    32'(out_valid), 32'h0);
        check("rp_addr",     imem_addr,      32'h100);
        tick();
        check("rp_valid",    32'(out_valid), 32'h1);
        check("rp_pc",       out_pc,         32'h100);
        check("rp_inst",     out_inst,       inst_of(32'h100));
        tick();
        check("rp_next_pc",  out_pc,         32'h104);

        // fetch_pc wraparound
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        check("wr_addr0", imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wr_addr1", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wr_addr2", imem_addr, 32'h0);
        check("wr_pc1",   out_pc,    32'hFFFF_FFFC);
        tick();
        check("wr_pc2",   out_pc,    32'h0);

        // Asynchronous reset in the middle of a pending request
        mem_lat = 3;
        tick();
        tick();
        check("ar_pre_req", 32'(imem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("ar_req",   32'(imem_req),  32'h0);
        check("ar_addr",  imem_addr,      32'h0);
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_pc",    out_pc,         32'h0);
        tick();
        rst     = 1'b0;
        mem_lat = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
        do_reset();
        tick();
        tick();
        check("ma_fault0", 32'(misalign_fault), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        check("ma_fault1", 32'(misalign_fault), 32'h1);
        check("ma_req0",   32'(imem_req),       32'h0);
        check("ma_valid",  32'(out_valid),      32'h0);
        tick();
        tick();
        check("ma_fault2", 32'(misalign_fault), 32'h1);
        check("ma_req1",   32'(imem_req),       32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("ma_clear",  32'(misalign_fault), 32'h0);
        check("ma_req2",   32'(imem_req),       32'h1);
        check("ma_addr",   imem_addr,           32'h200);
        tick();
        check("ma_pc",     out_pc,              32'h200);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the instruction memory and the control unit. Generates the sequential fetch PC, issues single-outstanding requests to instruction memory, buffers returned words with their PCs in a small queue, and presents them to decode over a valid/ready handshake. Redirects from the control unit (taken branches and jumps) flush the queue and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, queue entries; power of two, 2..8

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  request to instruction memory; held until acked
- imem_addr  out  32  word-aligned fetch address; stable while imem_req high
- imem_ack  in  1  response valid; sampled only while imem_req high; may assert in the first req cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_inst  out  32  head instruction
- out_pc  out  32  head PC
- misalign_fault  out  1  only with FETCH_MISALIGN_CHECK_EN

## Operation
- State register: IDLE (no request), REQ (request to fetch_pc outstanding), FLUSH (stale request outstanding; response to be dropped).
- Registers: fetch_pc, req_addr, queue (DEPTH × {pc, inst}), count (0..DEPTH).
- IDLE: if count_next < DEPTH, go to REQ with req_addr <= fetch_pc.
- REQ with imem_ack: push {req_addr, imem_rdata}, fetch_pc += 4 (mod 2^32). Go to REQ at the new fetch_pc if count_next < DEPTH, else IDLE.
- At most one request outstanding. A request is issued only when the queue has room, so a push never overflows.
- Pop: when out_valid && out_ready, advance head and decrement count. Push and pop in the same cycle leave count unchanged.
- Redirect, which has priority over everything else:
  - Clear the queue (count <= 0) and set fetch_pc <= redirect_pc.
  - In REQ without ack: go to FLUSH. In REQ with ack: drop the data and go to REQ at redirect_pc. In IDLE: go to REQ at redirect_pc.
  - In FLUSH: update fetch_pc and stay in FLUSH.
- A pop in the redirect cycle is a completed transfer; the consumer owns that word.
- FLUSH with imem_ack: drop the data and go to REQ at fetch_pc.
- imem_addr = req_addr. imem_req = (state != IDLE).
- Empty queue: out_valid = 0, out_inst = 32'h0000_0013 (NOP), out_pc = fetch_pc.

## Timing
- Reset values: state IDLE, fetch_pc = req_addr = RESET_PC, count = 0, imem_req = 0, imem_addr = RESET_PC, out_valid = 0, out_inst = 32'h0000_0013, out_pc = RESET_PC, misalign_fault = 0.
- First imem_req in the first cycle after rst deasserts.
- With a zero-wait memory (ack in the same cycle as req) and out_ready held high:
  - one instruction per cycle;
  - word fetched in cycle n appears on out_* in cycle n+1.
- Redirect in cycle n, zero-wait memory: the request to redirect_pc is on imem_addr in cycle n+1, and its data appears on out_* in cycle n+2.
- Reset asserted mid-request: everything returns to reset values immediately. A late ack is ignored because it is sampled only while imem_req is high.
- fetch_pc wraps from 32'hFFFF_FFFC to 32'h0000_0000.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets misalign_fault high and leaves it high.
  - That redirect still flushes the queue, but the block then issues no new requests; an in-flight request completes through FLUSH.
  - The fault clears only on an aligned redirect (which restarts fetch at that address) or on reset.
- Not defined: the misalign_fault port is absent, and redirect_pc[1:0] is treated as 2'b00.

## Test plan
- Reset, zero-wait memory, out_ready = 1 -> out_pc = 0, 4, 8, … on consecutive cycles; out_inst = memory contents.
- out_ready = 0, DEPTH = 2 -> exactly 2 acks are accepted, then imem_req = 0. Raising out_ready pops PC 0, then 4, and fetch resumes at 8.
- Memory with 3-cycle ack latency, redirect to 32'h100 in the second wait cycle -> stale data is dropped, the next imem_addr = 32'h100, and out_valid never shows the stale word.
- Redirect in the same cycle as imem_ack and a pop -> popped word is delivered, acked word is dropped, the queue is empty next cycle, and out_pc = 32'h100 two cycles later.
- fetch_pc = 32'hFFFF_FFFC -> the next fetch address is 0.
- FETCH_MISALIGN_CHECK_EN, redirect_pc = 32'h102 -> misalign_fault = 1 and imem_req stays 0. A later redirect to 32'h200 clears the fault and fetches 32'h200.
